// File: rtl/ram_port_arbiter_if.sv
// Two-requester / single RAM port bundle for ram_port_arbiter.
// slave = arbiter side, master = requesters plus the RAM port.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  ram_dout,
    output req0_ready, req1_ready,
    output ram_we, ram_addr, ram_din,
    output rsp0_valid, rsp0_rdata,
    output rsp1_valid, rsp1_rdata,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output ram_dout,
    input  req0_ready, req1_ready,
    input  ram_we, ram_addr, ram_din,
    input  rsp0_valid, rsp0_rdata,
    input  rsp1_valid, rsp1_rdata,
    input  busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Host/DMA arbiter feeding one RAM port with tagged read returns.
// ARB_REQ0_PRIORITY_EN: strict req0 priority with starvation escape.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  ram_port_arbiter_if.slave   bus
);

  localparam int DEPTH = RD_LATENCY + 1;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_gnt;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_rd;

  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din;

  logic [DEPTH-1:0]      r_tag_v;
  logic [DEPTH-1:0]      r_tag_id;

  logic                  r_rsp0_v;
  logic                  r_rsp1_v;
  logic [DATA_WIDTH-1:0] r_rsp0_d;
  logic [DATA_WIDTH-1:0] r_rsp1_d;

`ifdef ARB_REQ0_PRIORITY_EN
  logic [2:0] r_starve;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (r_starve >= 3'd4) w_gnt1 = 1'b1;
        else                  w_gnt0 = 1'b1;
      end else begin
        w_gnt0 = bus.req0_valid;
        w_gnt1 = bus.req1_valid;
      end
    end
  end

  // counts req0 wins while req1 waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 3'd0;
    end else if (w_gnt1 || !bus.req1_valid) begin
      r_starve <= 3'd0;
    end else if (w_gnt0) begin
      r_starve <= r_starve + 3'd1;
    end
  end
`else
  logic r_ptr;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt0 = ~r_ptr;
        w_gnt1 = r_ptr;
      end else begin
        w_gnt0 = bus.req0_valid;
        w_gnt1 = bus.req1_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_gnt0) begin
      r_ptr <= 1'b1;
    end else if (w_gnt1) begin
      r_ptr <= 1'b0;
    end
  end
`endif

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  always_comb begin
    w_gnt   = w_gnt0 | w_gnt1;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (1'b1)
      w_gnt1: begin
        w_we    = bus.req1_we;
        w_addr  = bus.req1_addr;
        w_wdata = bus.req1_wdata;
      end
      w_gnt0: begin
        w_we    = bus.req0_we;
        w_addr  = bus.req0_addr;
        w_wdata = bus.req0_wdata;
      end
      default: ;
    endcase
    w_rd = w_gnt & ~w_we;
  end

  // issue register: idle cycles only drop the write enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else if (w_gnt) begin
      r_ram_we   <= w_we;
      r_ram_addr <= w_addr;
      if (w_we) r_ram_din <= w_wdata;
    end else begin
      r_ram_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[DEPTH-2:0], w_rd};
      r_tag_id <= {r_tag_id[DEPTH-2:0], w_gnt1};
    end
  end

  // last tag stage lines up with valid ram_dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_v <= 1'b0;
      r_rsp1_v <= 1'b0;
      r_rsp0_d <= '0;
      r_rsp1_d <= '0;
    end else begin
      r_rsp0_v <= r_tag_v[DEPTH-1] & ~r_tag_id[DEPTH-1];
      r_rsp1_v <= r_tag_v[DEPTH-1] &  r_tag_id[DEPTH-1];
      if (r_tag_v[DEPTH-1] && !r_tag_id[DEPTH-1])
        r_rsp0_d <= bus.ram_dout;
      if (r_tag_v[DEPTH-1] && r_tag_id[DEPTH-1])
        r_rsp1_d <= bus.ram_dout;
    end
  end

  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_din    = r_ram_din;
  assign bus.rsp0_valid = r_rsp0_v;
  assign bus.rsp0_rdata = r_rsp0_d;
  assign bus.rsp1_valid = r_rsp1_v;
  assign bus.rsp1_rdata = r_rsp1_d;
  assign bus.busy       = r_ram_we | (|r_tag_v);

endmodule
